// File: rtl/stopwatch_counter_pkg.sv
// Shared constants, state encoding and helpers for the stopwatch counter.
package stopwatch_counter_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_PAUSE = 2'd1,
        S_ADJ   = 2'd2
    } sw_state_t;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned MAX_MIN_DEF     = 59;
    localparam int unsigned MAX_SEC_DEF     = 59;

    // Compare-to-max before adding so the field never exceeds its wrap value.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
        return (value == max) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/stopwatch_counter_tick_sync.sv
// Synchronises a divider toggle level into clk and flags each rising edge for one cycle.
module stopwatch_counter_tick_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_level,
    output logic o_rise_tick
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_level};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level     = r_sync[SYNC_STAGES-1];
    assign o_rise_tick = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch driven by synchronised divider levels, with run/pause/adjust control and blanking.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned MAX_MIN     = MAX_MIN_DEF,
    parameter int unsigned MAX_SEC     = MAX_SEC_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clk_1hz,
    input  logic       i_clk_2hz,
    input  logic       i_clk_blink,
    input  logic       i_pause,
    input  logic       i_clear,
    input  logic       i_adj,
    input  logic       i_sel,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic       o_blank_min,
    output logic       o_blank_sec,
    output logic       o_running
);

    localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);
    localparam logic [5:0] MAX_SEC_V = 6'(MAX_SEC);

    logic      w_tick_1hz, w_tick_2hz, w_blink;
    logic      w_level_1hz_unused, w_level_2hz_unused, w_blink_rise_unused;
    sw_state_t r_state, w_state_next;
    logic [5:0] r_min, r_sec, w_min_next, w_sec_next;
    logic      r_blank_min, r_blank_sec, r_running;

    stopwatch_counter_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_1hz (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_level     (i_clk_1hz),
        .o_level     (w_level_1hz_unused),
        .o_rise_tick (w_tick_1hz)
    );

    stopwatch_counter_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_2hz (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_level     (i_clk_2hz),
        .o_level     (w_level_2hz_unused),
        .o_rise_tick (w_tick_2hz)
    );

    stopwatch_counter_tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_blink (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_level     (i_clk_blink),
        .o_level     (w_blink),
        .o_rise_tick (w_blink_rise_unused)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_RUN: begin
                if (i_adj)        w_state_next = S_ADJ;
                else if (i_pause) w_state_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (i_adj)        w_state_next = S_ADJ;
                else if (i_pause) w_state_next = S_RUN;
            end
            S_ADJ: begin
                if (!i_adj)       w_state_next = S_PAUSE;
            end
            default:              w_state_next = S_RUN;
        endcase
    end

    // Clear has priority over any tick; adjust increments never carry between fields.
    always_comb begin
        w_min_next = r_min;
        w_sec_next = r_sec;
        if (i_clear) begin
            w_min_next = 6'd0;
            w_sec_next = 6'd0;
        end else if (r_state == S_RUN && w_tick_1hz) begin
            w_sec_next = wrap_inc(r_sec, MAX_SEC_V);
            if (r_sec == MAX_SEC_V) w_min_next = wrap_inc(r_min, MAX_MIN_V);
        end else if (r_state == S_ADJ && w_tick_2hz) begin
            if (i_sel) w_sec_next = wrap_inc(r_sec, MAX_SEC_V);
            else       w_min_next = wrap_inc(r_min, MAX_MIN_V);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_RUN;
            r_running   <= 1'b1;
            r_min       <= 6'd0;
            r_sec       <= 6'd0;
            r_blank_min <= 1'b0;
            r_blank_sec <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_running   <= (w_state_next == S_RUN);
            r_min       <= w_min_next;
            r_sec       <= w_sec_next;
            r_blank_min <= (r_state == S_ADJ) & w_blink & ~i_sel;
            r_blank_sec <= (r_state == S_ADJ) & w_blink & i_sel;
        end
    end

    assign o_minutes   = r_min;
    assign o_seconds   = r_sec;
    assign o_blank_min = r_blank_min;
    assign o_blank_sec = r_blank_sec;
    assign o_running   = r_running;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench: vector table, directed corner sequences and randomized run vs. reference model.
module tb_stopwatch_counter;

    localparam int MM = 59;
    localparam int MS = 59;

    logic       clk = 1'b0;
    logic       rst, c1, c2, cb, pause, clear, adj, sel;
    logic [5:0] minutes, seconds;
    logic       blank_min, blank_sec, running;

    int total = 0;
    int bad   = 0;

    // Reference model: time as a single seconds count, inputs as a per-edge history.
    int         m_min, m_sec, m_st;  // m_st: 0 run, 1 pause, 2 adjust
    logic       m_bmin, m_bsec;
    logic [3:0] h1, h2, hb;

    typedef struct {
        string name;
        logic  c1, c2, cb, adj, sel, pause, clear;
        int    emin, esec;
        logic  erun, ebm, ebs;
    } vec_t;

    vec_t vecs[17];

    always #5 clk = ~clk;

    stopwatch_counter #(.SYNC_STAGES(2), .MAX_MIN(MM), .MAX_SEC(MS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clk_1hz   (c1),
        .i_clk_2hz   (c2),
        .i_clk_blink (cb),
        .i_pause     (pause),
        .i_clear     (clear),
        .i_adj       (adj),
        .i_sel       (sel),
        .o_minutes   (minutes),
        .o_seconds   (seconds),
        .o_blank_min (blank_min),
        .o_blank_sec (blank_sec),
        .o_running   (running)
    );

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_st = 0; m_bmin = 1'b0; m_bsec = 1'b0;
        h1 = '0; h2 = '0; hb = '0;
    endtask

    task automatic model_edge();
        logic t1, t2, blink;
        int   ns, tot;
        h1 = {h1[2:0], c1};
        h2 = {h2[2:0], c2};
        hb = {hb[2:0], cb};
        // A level seen at an edge becomes a tick two edges later, acting on the third.
        t1 = h1[2] & ~h1[3];
        t2 = h2[2] & ~h2[3];
        blink = hb[2];
        ns = m_st;
        if (m_st == 2) begin
            if (!adj) ns = 1;
        end else if (adj) ns = 2;
        else if (pause) ns = (m_st == 0) ? 1 : 0;
        if (clear) begin
            m_min = 0; m_sec = 0;
        end else if (m_st == 0 && t1) begin
            tot = (m_min * (MS + 1) + m_sec + 1) % ((MM + 1) * (MS + 1));
            m_min = tot / (MS + 1);
            m_sec = tot % (MS + 1);
        end else if (m_st == 2 && t2) begin
            if (sel) m_sec = (m_sec + 1) % (MS + 1);
            else     m_min = (m_min + 1) % (MM + 1);
        end
        m_bmin = (m_st == 2) && blink && !sel;
        m_bsec = (m_st == 2) && blink && sel;
        m_st = ns;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_out(input string name, input int emin, input int esec,
                             input logic erun, input logic ebm, input logic ebs);
        total++;
        if (minutes !== 6'(emin) || seconds !== 6'(esec) || running !== erun ||
            blank_min !== ebm || blank_sec !== ebs) begin
            bad++;
            $display("FAIL %s: got %0d:%0d run=%b bm=%b bs=%b, expected %0d:%0d run=%b bm=%b bs=%b",
                     name, minutes, seconds, running, blank_min, blank_sec,
                     emin, esec, erun, ebm, ebs);
        end
    endtask

    task automatic check_model(input string name);
        check_out(name, m_min, m_sec, (m_st == 0), m_bmin, m_bsec);
    endtask

    task automatic pulse_pause();
        pause = 1'b1; step(); pause = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic edge_2hz(input int n);
        for (int i = 0; i < n; i++) begin
            c2 = 1'b1; steps(3);
            c2 = 1'b0; steps(3);
        end
    endtask

    task automatic edge_1hz(input int n);
        for (int i = 0; i < n; i++) begin
            c1 = 1'b1; steps(3);
            c1 = 1'b0; steps(3);
        end
    endtask

    task automatic hard_reset();
        rst = 1'b1; c1 = 0; c2 = 0; cb = 0; pause = 0; clear = 0; adj = 0; sel = 0;
        model_reset();
        steps(3);
        rst = 1'b0;
        steps(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{"adj_enter",    0, 0, 0, 1, 1, 0, 0,  0,  0, 1'b0, 1'b0, 1'b0},
            '{"adj_sec_inc",  0, 1, 0, 1, 1, 0, 0,  0,  1, 1'b0, 1'b0, 1'b0},
            '{"c2_fall",      0, 0, 0, 1, 1, 0, 0,  0,  1, 1'b0, 1'b0, 1'b0},
            '{"adj_sec_inc2", 0, 1, 0, 1, 1, 0, 0,  0,  2, 1'b0, 1'b0, 1'b0},
            '{"1hz_ignored",  1, 0, 0, 1, 1, 0, 0,  0,  2, 1'b0, 1'b0, 1'b0},
            '{"adj_min_inc",  0, 1, 0, 1, 0, 0, 0,  1,  2, 1'b0, 1'b0, 1'b0},
            '{"blank_min",    0, 0, 1, 1, 0, 0, 0,  1,  2, 1'b0, 1'b1, 1'b0},
            '{"blank_sec",    0, 0, 1, 1, 1, 0, 0,  1,  2, 1'b0, 1'b0, 1'b1},
            '{"adj_pause_ign",0, 0, 1, 1, 1, 1, 0,  1,  2, 1'b0, 1'b0, 1'b1},
            '{"exit_adj",     0, 0, 1, 0, 1, 0, 0,  1,  2, 1'b0, 1'b0, 1'b0},
            '{"resume",       0, 0, 1, 0, 1, 1, 0,  1,  2, 1'b1, 1'b0, 1'b0},
            '{"run_tick",     1, 0, 1, 0, 1, 0, 0,  1,  3, 1'b1, 1'b0, 1'b0},
            '{"run_fall",     0, 0, 1, 0, 1, 0, 0,  1,  3, 1'b1, 1'b0, 1'b0},
            '{"clear_run",    0, 0, 1, 0, 1, 0, 1,  0,  0, 1'b1, 1'b0, 1'b0},
            '{"pause",        0, 0, 1, 0, 1, 1, 0,  0,  0, 1'b0, 1'b0, 1'b0},
            '{"paused_hold",  1, 0, 1, 0, 1, 0, 0,  0,  0, 1'b0, 1'b0, 1'b0},
            '{"pause_to_adj", 1, 0, 0, 1, 0, 0, 0,  0,  0, 1'b0, 1'b0, 1'b0}
        };

        hard_reset();
        check_out("reset", 0, 0, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            c1 = vecs[i].c1; c2 = vecs[i].c2; cb = vecs[i].cb;
            adj = vecs[i].adj; sel = vecs[i].sel;
            pause = vecs[i].pause; clear = vecs[i].clear;
            step();
            pause = 1'b0; clear = 1'b0;
            steps(3);
            check_out(vecs[i].name, vecs[i].emin, vecs[i].esec,
                      vecs[i].erun, vecs[i].ebm, vecs[i].ebs);
        end

        // 60 one-second edges, each stepping exactly on the third clock edge
        hard_reset();
        for (int k = 0; k < 60; k++) begin
            c1 = 1'b1;
            step(); check_out("t1_lat1", k / 60, k % 60, 1'b1, 1'b0, 1'b0);
            step(); check_out("t1_lat2", k / 60, k % 60, 1'b1, 1'b0, 1'b0);
            step(); check_out("t1_step", (k + 1) / 60, (k + 1) % 60, 1'b1, 1'b0, 1'b0);
            c1 = 1'b0;
            steps(3); check_out("t1_fall", (k + 1) / 60, (k + 1) % 60, 1'b1, 1'b0, 1'b0);
        end

        // Full wrap 59:59 -> 00:00
        adj = 1'b1; sel = 1'b0; steps(2);
        pulse_clear();
        edge_2hz(59);
        sel = 1'b1;
        edge_2hz(59);
        check_out("t2_preload", 59, 59, 1'b0, 1'b0, 1'b0);
        adj = 1'b0; steps(2);
        check_out("t2_paused", 59, 59, 1'b0, 1'b0, 1'b0);
        pulse_pause(); steps(1);
        check_out("t2_running", 59, 59, 1'b1, 1'b0, 1'b0);
        edge_1hz(1);
        check_out("t2_wrap", 0, 0, 1'b1, 1'b0, 1'b0);

        // Adjust seconds wrap without carry; 1 Hz ignored in adjust
        adj = 1'b1; sel = 1'b0; steps(2);
        edge_2hz(3);
        sel = 1'b1;
        edge_2hz(58);
        check_out("t3_pre", 3, 58, 1'b0, 1'b0, 1'b0);
        edge_2hz(1); check_out("t3_59", 3, 59, 1'b0, 1'b0, 1'b0);
        edge_2hz(1); check_out("t3_wrap", 3, 0, 1'b0, 1'b0, 1'b0);
        edge_2hz(1); check_out("t3_1", 3, 1, 1'b0, 1'b0, 1'b0);
        edge_1hz(2); check_out("t3_1hz_ign", 3, 1, 1'b0, 1'b0, 1'b0);

        // Pause coincident with a run tick
        pulse_clear();
        adj = 1'b0; steps(2);
        pulse_pause(); steps(1);
        edge_1hz(5);
        check_out("t4_pre", 0, 5, 1'b1, 1'b0, 1'b0);
        c1 = 1'b1; steps(2);
        pulse_pause();
        check_out("t4_pause_tick", 0, 6, 1'b0, 1'b0, 1'b0);
        c1 = 1'b0; steps(3);
        edge_1hz(2);
        check_out("t4_hold", 0, 6, 1'b0, 1'b0, 1'b0);

        // Blanking follows blink and field select only in adjust
        adj = 1'b1; sel = 1'b0; cb = 1'b1; steps(4);
        check_out("t5_blank", 0, 6, 1'b0, 1'b1, 1'b0);
        adj = 1'b0; steps(3);
        check_out("t5_exit", 0, 6, 1'b0, 1'b0, 1'b0);
        cb = 1'b0;

        // Mid-cycle async reset with an in-flight tick, then clear beating a tick
        adj = 1'b1; steps(2);
        pulse_clear();
        sel = 1'b0; edge_2hz(12);
        sel = 1'b1; edge_2hz(34);
        adj = 1'b0; steps(2);
        pulse_pause(); steps(1);
        check_out("t6_pre", 12, 34, 1'b1, 1'b0, 1'b0);
        c1 = 1'b1; step();
        #2 rst = 1'b1; c1 = 1'b0; model_reset();
        #1 check_out("t6_async_rst", 0, 0, 1'b1, 1'b0, 1'b0);
        steps(2);
        rst = 1'b0;
        steps(4);
        check_out("t6_no_stale_tick", 0, 0, 1'b1, 1'b0, 1'b0);
        edge_1hz(3);
        check_out("t6_three", 0, 3, 1'b1, 1'b0, 1'b0);
        c1 = 1'b1; steps(2);
        pulse_clear();
        check_out("t6_clear_tick", 0, 0, 1'b1, 1'b0, 1'b0);
        c1 = 1'b0; steps(3);

        // Randomized run against the reference model
        hard_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0)   c1 = ~c1;
            if ($urandom_range(0, 2) == 0)   c2 = ~c2;
            if ($urandom_range(0, 7) == 0)   cb = ~cb;
            if ($urandom_range(0, 39) == 0)  adj = ~adj;
            if ($urandom_range(0, 9) == 0)   sel = ~sel;
            pause = ($urandom_range(0, 14) == 0);
            clear = ($urandom_range(0, 199) == 0);
            step();
            check_model("rand");
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1; model_reset();
                #1 check_model("rand_rst");
                steps(2);
                rst = 1'b0;
            end
        end
        pause = 1'b0; clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
